pool_control_gen: RTL and testbench

POOL_CONTROL_GEN -- requirements
Module: pool_control_gen

---
 rtl/pool_pkg.sv | 15 +
 rtl/wrap_counter.sv | 24 ++
 rtl/pool_control_gen.sv | 118 +++++++++++
 tb/tb_pool_control_gen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared acc_src encodings, counter sizing helper and parameter legality check
package pool_pkg;
   typedef enum logic [1:0] {
      SRC_LOAD    = 2'b00,
      SRC_LB      = 2'b01,
      SRC_ACC     = 2'b10,
      SRC_DISCARD = 2'b11
   } acc_src_t;
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic bit pool_legal(input int w, input int h, input int p);
      return (p >= 2) && (w >= p) && (h >= p);
   endfunction
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MOD counter with enable, sync clear and wrap flag
//   i_rst_n async active-low reset, i_clr sync clear (wins over i_en),
//   i_en advance, o_cnt current count, o_wrap = i_en at count MOD-1
module wrap_counter
   import pool_pkg::*;
#(
   parameter int MOD = 2,
   parameter int W   = cw(MOD)
) (
   input  logic         clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_wrap
);
   logic [W-1:0] r_cnt;
   assign o_wrap = i_en && (r_cnt == W'(MOD - 1));
   assign o_cnt  = r_cnt;
   always_ff @(posedge clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/pool_control_gen.sv
// pool_control_gen: raster-order pooling window controller
//   in_valid/in_ready  pixel handshake, stalled only while a result waits on out_ready
//   ctl_valid/acc_src/lb_push  per-pixel control, one cycle after acceptance
//   out_valid/out_ready/out_col/out_row  window result handshake and coordinates
//   avg_mode  avg_mode_in latched on each frame's first pixel; frame_done last-pixel pulse
//   master_rst_n async reset; frame_abort sync soft clear that drops a coincident pixel
module pool_control_gen
   import pool_pkg::*;
#(
   parameter int IMG_W = 26,
   parameter int IMG_H = 26,
   parameter int POOL  = 2,
   localparam int OCW  = cw(IMG_W / POOL),
   localparam int ORW  = cw(IMG_H / POOL)
) (
   input  logic           clk,
   input  logic           master_rst_n,
   input  logic           frame_abort,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           avg_mode_in,
   output logic           ctl_valid,
   output logic [1:0]     acc_src,
   output logic           lb_push,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [OCW-1:0] out_col,
   output logic [ORW-1:0] out_row,
   output logic           avg_mode,
   output logic           frame_done
);
   // orow also spans a trailing partial window row, whose pixels are cropped
   localparam int OROWS = (IMG_H + POOL - 1) / POOL;
   localparam int XLIM  = (IMG_W / POOL) * POOL;
   localparam int YLIM  = IMG_H / POOL;
   localparam int LASTW = IMG_H - 1 - (OROWS - 1) * POOL;
   localparam int CW_C  = cw(IMG_W);
   localparam int CW_W  = cw(POOL);
   localparam int CW_R  = cw(OROWS);

   if (!pool_legal(IMG_W, IMG_H, POOL)) begin : g_illegal
      $error("pool_control_gen: illegal IMG_W/IMG_H/POOL combination");
   end

   logic [CW_C-1:0] w_col;
   logic [CW_W-1:0] w_wrow;
   logic [CW_R-1:0] w_orow;
   logic [CW_W-1:0] w_c;
   logic            w_col_wrap, w_wrow_wrap, w_orow_wrap;
   logic            w_acc, w_last, w_clr, w_crop, w_clast, w_wlast, w_first;
   acc_src_t        w_src;

   acc_src_t        r_src;
   logic            r_ctl_valid, r_lb_push, r_out_valid, r_avg_mode, r_frame_done;
   logic [OCW-1:0]  r_out_col;
   logic [ORW-1:0]  r_out_row;

   assign in_ready = !(r_out_valid && !out_ready);
   assign w_acc    = in_valid && in_ready && !frame_abort;
   assign w_last   = (w_col == CW_C'(IMG_W - 1)) && (w_orow == CW_R'(OROWS - 1)) &&
                     (w_wrow == CW_W'(LASTW));
   // an orow wrap can only coincide with the frame's last pixel, so it is a safe extra clear term
   assign w_clr    = frame_abort || (w_acc && w_last) || w_orow_wrap;
   assign w_c      = CW_W'(int'(w_col) % POOL);
   assign w_crop   = (int'(w_col) >= XLIM) || (int'(w_orow) >= YLIM);
   assign w_clast  = !w_crop && (w_c == CW_W'(POOL - 1));
   assign w_wlast  = w_wrow == CW_W'(POOL - 1);
   assign w_first  = (w_col == '0) && (w_wrow == '0) && (w_orow == '0);
   assign w_src    = w_crop ? SRC_DISCARD : (w_c != '0) ? SRC_ACC :
                     (w_wrow == '0) ? SRC_LOAD : SRC_LB;

   wrap_counter #(.MOD(IMG_W)) u_col (
      .clk(clk), .i_rst_n(master_rst_n), .i_clr(w_clr), .i_en(w_acc),
      .o_cnt(w_col), .o_wrap(w_col_wrap)
   );
   wrap_counter #(.MOD(POOL)) u_wrow (
      .clk(clk), .i_rst_n(master_rst_n), .i_clr(w_clr), .i_en(w_col_wrap),
      .o_cnt(w_wrow), .o_wrap(w_wrow_wrap)
   );
   wrap_counter #(.MOD(OROWS)) u_orow (
      .clk(clk), .i_rst_n(master_rst_n), .i_clr(w_clr), .i_en(w_wrow_wrap),
      .o_cnt(w_orow), .o_wrap(w_orow_wrap)
   );

   always_ff @(posedge clk or negedge master_rst_n)
      if (!master_rst_n) begin
         r_ctl_valid  <= 1'b0;
         r_src        <= SRC_LOAD;
         r_lb_push    <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_col    <= '0;
         r_out_row    <= '0;
         r_avg_mode   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_ctl_valid  <= w_acc;
         r_lb_push    <= w_acc && w_clast && !w_wlast;
         r_frame_done <= w_acc && w_last;
         if (w_acc) r_src <= w_src;
         if (w_acc && w_first) r_avg_mode <= avg_mode_in;
         // a new result may load in the same cycle the previous one is taken
         if (frame_abort) r_out_valid <= 1'b0;
         else if (w_acc && w_clast && w_wlast) begin
            r_out_valid <= 1'b1;
            r_out_col   <= OCW'(int'(w_col) / POOL);
            r_out_row   <= ORW'(w_orow);
         end else if (out_ready) r_out_valid <= 1'b0;
      end

   assign ctl_valid  = r_ctl_valid;
   assign acc_src    = r_src;
   assign lb_push    = r_lb_push;
   assign out_valid  = r_out_valid;
   assign out_col    = r_out_col;
   assign out_row    = r_out_row;
   assign avg_mode   = r_avg_mode;
   assign frame_done = r_frame_done;
endmodule

// File: tb/tb_pool_control_gen.sv
// tb_pool_control_gen: randomized and directed checks of pool_control_gen against a pixel-index model
module tb_pool_control_gen;
   localparam int W   = 5;
   localparam int H   = 5;
   localparam int P   = 2;
   localparam int OCW = (W / P > 1) ? $clog2(W / P) : 1;
   localparam int ORW = (H / P > 1) ? $clog2(H / P) : 1;

   logic           clk = 1'b0;
   logic           master_rst_n = 1'b0;
   logic           frame_abort = 1'b0;
   logic           in_valid = 1'b0;
   logic           avg_mode_in = 1'b0;
   logic           out_ready = 1'b0;
   logic           in_ready, ctl_valid, lb_push, out_valid, avg_mode, frame_done;
   logic [1:0]     acc_src;
   logic [OCW-1:0] out_col;
   logic [ORW-1:0] out_row;

   int n_checks = 0;
   int n_errors = 0;
   int n_out, n_fd;
   int m_n, e_src, e_oc, e_or;
   bit e_ctl, e_lb, e_ov, e_fd, e_avg;

   always #5 clk = ~clk;

   pool_control_gen #(.IMG_W(W), .IMG_H(H), .POOL(P)) dut (
      .clk(clk), .master_rst_n(master_rst_n), .frame_abort(frame_abort),
      .in_valid(in_valid), .in_ready(in_ready), .avg_mode_in(avg_mode_in),
      .ctl_valid(ctl_valid), .acc_src(acc_src), .lb_push(lb_push),
      .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
      .out_row(out_row), .avg_mode(avg_mode), .frame_done(frame_done)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_n = 0; e_src = 0; e_oc = 0; e_or = 0;
      e_ctl = 0; e_lb = 0; e_ov = 0; e_fd = 0; e_avg = 0;
   endtask

   task automatic check_outs();
      check("ctl_valid", ctl_valid, e_ctl);
      if (e_ctl) check("acc_src", acc_src, e_src);
      check("lb_push", lb_push, e_lb);
      check("out_valid", out_valid, e_ov);
      if (e_ov) begin
         check("out_col", out_col, e_oc);
         check("out_row", out_row, e_or);
      end
      check("frame_done", frame_done, e_fd);
      check("avg_mode", avg_mode, e_avg);
      if (frame_done) n_fd++;
   endtask

   // one clock: drive inputs after a falling edge, check in_ready, step the model, check registered outputs
   task automatic cycle(input bit iv, input bit ordy, input bit ab, input bit am);
      bit acc, crop, rdy;
      int x, y;
      in_valid = iv; out_ready = ordy; frame_abort = ab; avg_mode_in = am;
      #1;
      rdy = !(e_ov && !ordy);
      check("in_ready", in_ready, rdy);
      if (out_valid && ordy) n_out++;
      acc = iv && rdy && !ab;
      if (ab) begin
         m_n = 0; e_ctl = 0; e_lb = 0; e_ov = 0; e_fd = 0;
      end else begin
         if (e_ov && ordy) e_ov = 0;
         e_ctl = acc; e_lb = 0; e_fd = 0;
         if (acc) begin
            x = m_n % W;
            y = m_n / W;
            crop = (x >= (W / P) * P) || (y >= (H / P) * P);
            e_src = crop ? 3 : (x % P != 0) ? 2 : (y % P == 0) ? 0 : 1;
            if (!crop && x % P == P - 1) begin
               if (y % P == P - 1) begin
                  e_ov = 1; e_oc = x / P; e_or = y / P;
               end else e_lb = 1;
            end
            if (m_n == 0) e_avg = am;
            e_fd = (m_n == W * H - 1);
            m_n = e_fd ? 0 : m_n + 1;
         end
      end
      @(negedge clk);
      check_outs();
   endtask

   initial begin
      bit hit;
      m_reset();
      n_out = 0; n_fd = 0;
      repeat (2) @(negedge clk);
      check_outs();
      check("rst_acc_src", acc_src, 0);
      check("rst_out_col", out_col, 0);
      check("rst_out_row", out_row, 0);
      master_rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1);
      n_fd = 0;

      // two back-to-back frames, continuous valid, downstream always ready
      for (int i = 0; i < 2 * W * H; i++) cycle(1, 1, 0, 0);
      check("outputs_2frames", n_out, 2 * (W / P) * (H / P));
      check("frame_done_cnt", n_fd, 2);

      // stall three cycles on the first result of a frame
      hit = 0;
      for (int i = 0; i < 3 * W * H && !hit; i++) begin
         cycle(1, 1, 0, 1);
         hit = e_ov;
      end
      check("stall_reached", hit, 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
      for (int i = 0; i < 3 * W * H && m_n != 0; i++) cycle(1, 1, 0, 0);
      check("frame_end_reached", m_n, 0);

      // abort on pixel 6 (a window-completing pixel here) with valid high
      for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 0);
      cycle(1, 1, 0, 1);
      check("post_abort_src", acc_src, 0);
      for (int i = 0; i < W * H + 3; i++) cycle(1, 1, 0, 0);

      // random traffic, aborts and mode changes
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)));

      // reset mid-frame, then a new frame in average mode
      for (int i = 0; i < 3 * W * H && (m_n < 3 || e_ov); i++) cycle(1, 1, 0, 0);
      in_valid = 1'b1; out_ready = 1'b1;
      master_rst_n = 1'b0;
      #1;
      m_reset();
      check_outs();
      check("midrst_out_col", out_col, 0);
      check("midrst_out_row", out_row, 0);
      check("midrst_acc_src", acc_src, 0);
      @(negedge clk);
      check_outs();
      avg_mode_in = 1'b1;
      master_rst_n = 1'b1;
      cycle(1, 1, 0, 1);
      check("avg_latched", avg_mode, 1);
      for (int i = 0; i < 2 * W * H; i++) cycle(1, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
